// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift-by-N controller around a single-step shifter
// One shifter step per clock; start/done handshake with carry and zero flags.

module shifter (
  input  logic [7:0] A,
  input  logic       LA,
  input  logic       LR,
  output logic [7:0] Y,
  output logic       C
);
  always_comb begin
    Y = A;
    C = 1'b0;
    if (LR) begin
      // Arithmetic right replicates the sign bit; logical right fills with zero.
      Y = {LA & A[7], A[7:1]};
      C = A[0];
    end else begin
      Y = {A[6:0], 1'b0};
      C = A[7];
    end
  end
endmodule

module shift_sequencer #(
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       A,
  input  logic [AMT_W-1:0] AMT,
  input  logic             LR,
  input  logic             LA,
  output logic             busy,
  output logic             done,
  output logic [7:0]       Y,
  output logic             C,
  output logic             Z
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_y;
  logic [7:0]       w_y_nxt;
  logic             r_c;
  logic             w_c_nxt;
  logic [AMT_W-1:0] r_count;
  logic [AMT_W-1:0] w_count_nxt;
  logic             r_la;
  logic             w_la_nxt;
  logic             r_lr;
  logic             w_lr_nxt;
  logic             w_capture;
  logic [7:0]       w_sh_y;
  logic             w_sh_c;

  // Mode comes from the captured registers so input changes mid-shift are ignored.
  shifter u_shifter (
    .A  (r_y),
    .LA (r_la),
    .LR (r_lr),
    .Y  (w_sh_y),
    .C  (w_sh_c)
  );

  assign w_capture = start && (r_state != S_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_c_nxt     = r_c;
    w_count_nxt = r_count;
    w_la_nxt    = r_la;
    w_lr_nxt    = r_lr;
    case (r_state)
      S_SHIFT: begin
        w_y_nxt     = w_sh_y;
        w_c_nxt     = w_sh_c;
        w_count_nxt = r_count - AMT_W'(1);
        // The step taken with count==1 is the last one.
        if (r_count <= AMT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!w_capture) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_capture) begin
      w_y_nxt     = A;
      w_c_nxt     = 1'b0;
      w_count_nxt = AMT;
      w_la_nxt    = LA;
      w_lr_nxt    = LR;
      w_state_nxt = (AMT != '0) ? S_SHIFT : S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_y     <= 8'h00;
      r_c     <= 1'b0;
      r_count <= '0;
      r_la    <= 1'b0;
      r_lr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_y     <= w_y_nxt;
      r_c     <= w_c_nxt;
      r_count <= w_count_nxt;
      r_la    <= w_la_nxt;
      r_lr    <= w_lr_nxt;
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign Y    = r_y;
  assign C    = r_c;
  assign Z    = done && (r_y == 8'h00);
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer
// Linear directed steps; every comparison is an immediate assertion.

module tb_shift_sequencer;
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [2:0] AMT;
  logic       LR;
  logic       LA;
  logic       busy;
  logic       done;
  logic [7:0] Y;
  logic       C;
  logic       Z;

  int errors = 0;
  int checks = 0;

  shift_sequencer #(.AMT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .AMT   (AMT),
    .LR    (LR),
    .LA    (LA),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .C     (C),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [7:0] a, input logic [2:0] amt,
                             input logic lr, input logic la);
    start = 1'b1;
    A     = a;
    AMT   = amt;
    LR    = lr;
    LA    = la;
  endtask

  // Issue a start, count edges until done, and check latency, busy cycles and result.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [2:0] amt,
                        input logic lr, input logic la, input logic [7:0] ey,
                        input logic ec, input logic ez);
    int edges;
    int busy_cycles;
    edges       = 0;
    busy_cycles = 0;
    drive_start(a, amt, lr, la);
    step();
    edges++;
    start = 1'b0;
    A     = 8'h00;
    AMT   = 3'd0;
    while (!done && edges < 20) begin
      if (busy) busy_cycles++;
      step();
      edges++;
    end
    chk({tag, "_edges"}, edges, amt + 1);
    chk({tag, "_busy_cycles"}, busy_cycles, amt);
    chk({tag, "_Y"}, Y, ey);
    chk({tag, "_C"}, C, ec);
    chk({tag, "_Z"}, Z, ez);
  endtask

  initial begin
    int pulses;
    int edges;
    rst   = 1'b1;
    start = 1'b0;
    A     = 8'h00;
    AMT   = 3'd0;
    LR    = 1'b0;
    LA    = 1'b0;
    step();
    step();
    chk("rst_Y", Y, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    step();

    // Reset aborts an operation in progress.
    drive_start(8'hFF, 3'd5, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    chk("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("abort_Y", Y, 8'h00);
    chk("abort_C", C, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_Z", Z, 1'b0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) pulses++;
      step();
    end
    chk("abort_no_done", pulses, 0);

    run_op("lsl", 8'h96, 3'd3, 1'b0, 1'b0, 8'hB0, 1'b0, 1'b0);
    step();
    chk("lsl_done_one_cycle", done, 1'b0);
    chk("lsl_hold_Y", Y, 8'hB0);
    chk("lsl_Z_idle", Z, 1'b0);

    run_op("asr", 8'h96, 3'd2, 1'b1, 1'b1, 8'hE5, 1'b1, 1'b0);
    step();
    run_op("lsr_max", 8'h80, 3'd7, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0);
    step();
    run_op("lsr_zero", 8'h01, 3'd7, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step();

    // Zero amount, then a back-to-back start issued in the DONE cycle.
    run_op("amt0", 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
    drive_start(8'h01, 3'd1, 1'b0, 1'b0);
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done_low", done, 1'b0);
    step();
    chk("b2b_done", done, 1'b1);
    chk("b2b_Y", Y, 8'h02);
    chk("b2b_C", C, 1'b0);
    step();

    // A second start during SHIFT must be ignored.
    drive_start(8'h0F, 3'd4, 1'b0, 1'b0);
    step();
    drive_start(8'hFF, 3'd1, 1'b1, 1'b1);
    step();
    start = 1'b0;
    pulses = 0;
    edges  = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        chk("busystart_Y", Y, 8'hF0);
        chk("busystart_C", C, 1'b0);
        chk("busystart_edge", edges, 3);
      end
      step();
      edges++;
    end
    chk("busystart_pulses", pulses, 1);
    chk("busystart_hold_Y", Y, 8'hF0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
